// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle RV32 control FSM. It steps the shared-memory
// datapath one state per clock. A wait-state watchdog and an illegal-instruction
// check both lead to a sticky FAULT state that only rst can leave.
//
// Memory handshake: mem_req (with MemWrite/AdrSrc) stays asserted and stable
// from the first request cycle until the cycle in which mem_ready=1. That cycle
// completes the access and the FSM advances on the following edge. mem_ready is
// ignored in states that do not request.
module riscv_mc_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Sign,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             fault,
  output logic             bus_err,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] wait_cnt_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;
  logic             waiting;
  logic             timeout;
  logic             illegal;

  // Watchdog: expiry only counts while a request is still unanswered
  always_comb begin
    waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    timeout = waiting && !mem_ready && (wait_cnt == TIMEOUT_C);
  end

  // Illegal-instruction detection for the supported RV32 subset
  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: illegal = (funct3 != 3'b010);
      OP_R:      illegal = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}) ||
                           (funct7b5 && (funct3 != 3'b000));
      OP_I:      illegal = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
      OP_BRANCH: illegal = !(funct3 inside {3'b000, 3'b001, 3'b100});
      OP_JAL:    illegal = 1'b0;
      default:   illegal = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    state_nx = S_DECODE;
        else if (timeout) state_nx = S_FAULT;
      end
      S_DECODE: begin
        if (illegal) state_nx = S_FAULT;
        else begin
          case (op)
            OP_LOAD, OP_STORE: state_nx = S_MEMADR;
            OP_R:              state_nx = S_EXEC_R;
            OP_I:              state_nx = S_EXEC_I;
            OP_BRANCH:         state_nx = S_BRANCH;
            OP_JAL:            state_nx = S_JAL;
            default:           state_nx = S_FAULT;
          endcase
        end
      end
      S_MEMADR:  state_nx = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)    state_nx = S_MEMWB;
        else if (timeout) state_nx = S_FAULT;
      end
      S_MEMWB:   state_nx = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)    state_nx = S_FETCH;
        else if (timeout) state_nx = S_FAULT;
      end
      S_EXEC_R, S_EXEC_I: state_nx = S_ALUWB;
      S_ALUWB:   state_nx = S_FETCH;
      S_BRANCH:  state_nx = S_FETCH;
      S_JAL:     state_nx = S_ALUWB;
      default:   state_nx = S_FAULT;
    endcase
  end

  // State, wait counter and sticky bus-error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      // Outside an unanswered request the counter sits at zero, so every
      // waiting state is entered with a cleared count.
      if (waiting && !mem_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                   wait_cnt <= '0;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  // Datapath controls; rst forces everything quiet so no write can escape
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 2'b00;
    if (!rst) begin
      case (op)
        OP_STORE:  ImmSrc = 2'b01;
        OP_BRANCH: ImmSrc = 2'b10;
        OP_JAL:    ImmSrc = 2'b11;
        default:   ImmSrc = 2'b00;
      endcase
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXEC_R, S_EXEC_I: begin
          ALUSrcA = 2'b10;
          ALUSrcB = (state == S_EXEC_I) ? 2'b01 : 2'b00;
          case (funct3)
            3'b000:  ALUControl = (state == S_EXEC_R && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  ALUControl = 3'b101;
            3'b110:  ALUControl = 3'b011;
            3'b111:  ALUControl = 3'b010;
            default: ALUControl = 3'b000;
          endcase
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          case (funct3)
            3'b000:  PCWrite = Zero;
            3'b001:  PCWrite = !Zero;
            3'b100:  PCWrite = Sign;
            default: PCWrite = 1'b0;
          endcase
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fault        = (state == S_FAULT);
  assign bus_err      = bus_err_q;
  assign state_dbg    = state;
  assign wait_cnt_dbg = wait_cnt;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: table-driven cycle vectors for riscv_mc_ctrl with an
// expected-value queue, plus hand-written reset, fault and watchdog sequences.
module tb_riscv_mc_ctrl;

  localparam int W = 31;  // {state[3:0], controls[18:0], wait_cnt[7:0]}

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_FAULT = 4'd11;

  typedef logic [18:0] ctl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, s, r;
    logic [3:0] st;
    ctl_t       c;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] im;
  } ill_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, Zero = 1'b0, Sign = 1'b0, mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       fault, bus_err;
  logic [3:0] state_dbg;
  logic [7:0] wait_cnt_dbg;

  logic [W-1:0] exp_q[$];
  vec_t         tbl[$];
  ill_t         ill[$];
  int           n_cmp = 0;
  int           n_err = 0;

  riscv_mc_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .fault(fault), .bus_err(bus_err),
    .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "time limit");
  end

  // Expected control words: {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
  // ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, fault, bus_err}
  function automatic ctl_t mk(input logic mr, mw, as, ir, pw, rw,
                              input logic [1:0] rs, sa, sb, input logic [2:0] ac,
                              input logic [1:0] im, input logic f, be);
    return {mr, mw, as, ir, pw, rw, rs, sa, sb, ac, im, f, be};
  endfunction

  function automatic ctl_t f_fetch(input logic rdy, input logic [1:0] im);
    return mk(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, im, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_dec(input logic [1:0] im);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, im, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_alu(input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] im);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, ac, im, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_mem(input logic mw, input logic [1:0] im);
    return mk(1'b1, mw, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_wb(input logic [1:0] rs, input logic [1:0] im);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, 2'b00, 2'b00, 3'b000, im, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_br(input logic pw);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, pw, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_jal();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0);
  endfunction
  function automatic ctl_t f_fault(input logic be, input logic [1:0] im);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b1, be);
  endfunction

  function automatic void add(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, s, r,
                              input logic [3:0] st, input ctl_t c, input logic [7:0] cnt);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.s = s; v.r = r;
    v.st = st; v.c = c; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  // FETCH, DECODE, EXEC, ALUWB rows of one ALU instruction with mem_ready high
  function automatic void add_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic [3:0] ex_st, input ctl_t ex_c);
    add(o, f3, f7, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b00), 8'd0);
    add(o, f3, f7, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b00), 8'd0);
    add(o, f3, f7, 1'b0, 1'b0, 1'b1, ex_st, ex_c, 8'd0);
    add(o, f3, f7, 1'b0, 1'b0, 1'b1, S_ALUWB, f_wb(2'b00, 2'b00), 8'd0);
  endfunction

  // FETCH, DECODE, BRANCH rows of one branch
  function automatic void add_br(input logic [2:0] f3, input logic z, s, pw);
    add(OP_BR, f3, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b10), 8'd0);
    add(OP_BR, f3, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b10), 8'd0);
    add(OP_BR, f3, 1'b0, z, s, 1'b1, S_BRANCH, f_br(pw), 8'd0);
  endfunction

  // Scoreboard: pop the oldest expectation and compare with the sampled outputs
  task automatic check(input string nm);
    logic [W-1:0] act, e;
    act = {state_dbg, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, fault, bus_err, wait_cnt_dbg};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued", nm);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got state=%0d ctl=%05h cnt=%0d, want state=%0d ctl=%05h cnt=%0d",
                 nm, act[30:27], act[26:8], act[7:0], e[30:27], e[26:8], e[7:0]);
      end
    end
  endtask

  // Driver: apply one cycle of inputs just after a rising edge, compare at the falling edge
  task automatic cyc(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, z, s, r, input logic [3:0] st, input ctl_t c,
                     input logic [7:0] cnt);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; Sign = s; mem_ready = r;
    exp_q.push_back({st, c, cnt});
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  // Reset pulse; outputs must be quiet immediately and while held
  task automatic reset_dut(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.push_back({S_FETCH, 19'd0, 8'd0});
    check({nm, "_assert"});
    @(negedge clk);
    exp_q.push_back({S_FETCH, 19'd0, 8'd0});
    check({nm, "_held"});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // add, sub (after one fetch wait), or, slti, andi, addi with funct7b5 ignored
    add_alu(OP_R, 3'b000, 1'b0, S_EXEC_R, f_alu(2'b00, 3'b000, 2'b00));
    add(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, S_FETCH, f_fetch(1'b0, 2'b00), 8'd0);
    add_alu(OP_R, 3'b000, 1'b1, S_EXEC_R, f_alu(2'b00, 3'b001, 2'b00));
    tbl[5].cnt = 8'd1;
    add_alu(OP_R, 3'b110, 1'b0, S_EXEC_R, f_alu(2'b00, 3'b011, 2'b00));
    add_alu(OP_I, 3'b010, 1'b1, S_EXEC_I, f_alu(2'b01, 3'b101, 2'b00));
    add_alu(OP_I, 3'b111, 1'b0, S_EXEC_I, f_alu(2'b01, 3'b010, 2'b00));
    add_alu(OP_I, 3'b000, 1'b1, S_EXEC_I, f_alu(2'b01, 3'b000, 2'b00));
    // lw with three wait cycles in MEMREAD
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b00), 8'd0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b00), 8'd0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_MEMADR, f_alu(2'b01, 3'b000, 2'b00), 8'd0);
    for (int i = 0; i < 4; i++)
      add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, (i == 3), S_MEMREAD, f_mem(1'b0, 2'b00), 8'(i));
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_MEMWB, f_wb(2'b01, 2'b00), 8'd0);
    // sw with no wait
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b01), 8'd0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b01), 8'd0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_MEMADR, f_alu(2'b01, 3'b000, 2'b01), 8'd0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_MEMWRITE, f_mem(1'b1, 2'b01), 8'd0);
    // branches: beq/bne/blt taken and not taken
    add_br(3'b000, 1'b1, 1'b0, 1'b1);
    add_br(3'b001, 1'b1, 1'b0, 1'b0);
    add_br(3'b001, 1'b0, 1'b1, 1'b1);
    add_br(3'b000, 1'b0, 1'b1, 1'b0);
    add_br(3'b100, 1'b1, 1'b1, 1'b1);
    add_br(3'b100, 1'b1, 1'b0, 1'b0);
    // jal
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b11), 8'd0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b11), 8'd0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, S_JAL, f_jal(), 8'd0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, S_ALUWB, f_wb(2'b00, 2'b11), 8'd0);
    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b00), 8'd0);

    ill.push_back('{7'b1111111, 3'b000, 1'b0, 2'b00});
    ill.push_back('{OP_R,  3'b110, 1'b1, 2'b00});
    ill.push_back('{OP_R,  3'b001, 1'b0, 2'b00});
    ill.push_back('{OP_I,  3'b001, 1'b0, 2'b00});
    ill.push_back('{OP_BR, 3'b010, 1'b0, 2'b10});
    ill.push_back('{OP_LW, 3'b000, 1'b0, 2'b00});
    ill.push_back('{OP_SW, 3'b011, 1'b0, 2'b01});
    ill.push_back('{7'b0000000, 3'b010, 1'b0, 2'b00});

    reset_dut("reset_init");
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("tbl_%0d", i), tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].s,
          tbl[i].r, tbl[i].st, tbl[i].c, tbl[i].cnt);

    // Reset while a store is waiting: request and write strobe drop at once
    reset_dut("reset_pre_sw");
    cyc("sw_fetch", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b01), 8'd0);
    cyc("sw_decode", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b01), 8'd0);
    cyc("sw_memadr", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_MEMADR, f_alu(2'b01, 3'b000, 2'b01), 8'd0);
    cyc("sw_wait0", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, S_MEMWRITE, f_mem(1'b1, 2'b01), 8'd0);
    cyc("sw_wait1", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, S_MEMWRITE, f_mem(1'b1, 2'b01), 8'd1);
    #2;
    exp_q.push_back({S_MEMWRITE, f_mem(1'b1, 2'b01), 8'd2});
    check("sw_pre_rst");
    reset_dut("rst_mid_write");
    cyc("post_rst_fetch", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH, f_fetch(1'b0, 2'b01), 8'd0);

    // Illegal instructions: FAULT with bus_err=0, everything quiet, sticky
    for (int k = 0; k < ill.size(); k++) begin
      reset_dut($sformatf("rst_ill_%0d", k));
      cyc($sformatf("ill%0d_fetch", k), ill[k].op, ill[k].f3, ill[k].f7, 1'b0, 1'b0, 1'b1,
          S_FETCH, f_fetch(1'b1, ill[k].im), 8'd0);
      cyc($sformatf("ill%0d_decode", k), ill[k].op, ill[k].f3, ill[k].f7, 1'b0, 1'b0, 1'b1,
          S_DECODE, f_dec(ill[k].im), 8'd0);
      for (int j = 0; j < ((k == 0) ? 20 : 2); j++)
        cyc($sformatf("ill%0d_fault%0d", k, j), ill[k].op, ill[k].f3, ill[k].f7,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            S_FAULT, f_fault(1'b0, ill[k].im), 8'd0);
    end

    // Fetch watchdog: 16 unanswered request cycles, then FAULT with bus_err
    reset_dut("rst_to_fetch");
    for (int i = 0; i < 16; i++)
      cyc($sformatf("to_fetch%0d", i), OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
          S_FETCH, f_fetch(1'b0, 2'b00), 8'(i));
    for (int j = 0; j < 3; j++)
      cyc($sformatf("to_fault%0d", j), OP_R, 3'b000, 1'b0, 1'b0, 1'b0,
          1'($urandom_range(0, 1)), S_FAULT, f_fault(1'b1, 2'b00), 8'd0);

    // mem_ready on the last allowed cycle rescues the fetch
    reset_dut("rst_rescue");
    for (int i = 0; i < 16; i++)
      cyc($sformatf("rescue%0d", i), OP_R, 3'b000, 1'b0, 1'b0, 1'b0, (i == 15),
          S_FETCH, f_fetch(i == 15, 2'b00), 8'(i));
    cyc("rescue_decode", OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, S_DECODE, f_dec(2'b00), 8'd0);
    cyc("rescue_exec", OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, S_EXEC_R,
        f_alu(2'b00, 3'b000, 2'b00), 8'd0);

    // Load watchdog in MEMREAD
    reset_dut("rst_to_load");
    cyc("tol_fetch", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH, f_fetch(1'b1, 2'b00), 8'd0);
    cyc("tol_decode", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, f_dec(2'b00), 8'd0);
    cyc("tol_memadr", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_MEMADR, f_alu(2'b01, 3'b000, 2'b00), 8'd0);
    for (int i = 0; i < 16; i++)
      cyc($sformatf("tol_read%0d", i), OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
          S_MEMREAD, f_mem(1'b0, 2'b00), 8'(i));
    cyc("tol_fault", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, S_FAULT, f_fault(1'b1, 2'b00), 8'd0);
    reset_dut("rst_final");
    cyc("final_fetch", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH, f_fetch(1'b0, 2'b00), 8'd0);

    // Final report
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
